// File: rtl/cache_pkg.sv
// cache_pkg: shared state type and sizing helpers for the read cache controller
package cache_pkg;
  typedef enum logic [2:0] {IDLE, PROBE, MREQ, MWAIT, FILL} cache_rd_state_t;
  function automatic int beats_of(input int size_block, input int w_bus);
    return size_block / w_bus;
  endfunction
  function automatic int bytes_of(input int bits);
    return bits / 8;
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/cache_fill_seq.sv
// cache_fill_seq: SDRAM beat issue/receive counters, byte-address generation and block assembly
module cache_fill_seq
  import cache_pkg::*;
#(
  parameter int SIZE_BLOCK = 32,
  parameter int BIT_TOTAL = 24,
  parameter int W_BUS = 32,
  parameter int W_ADDR = 32,
  parameter logic [W_ADDR-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  issuing,
  input  logic                  collecting,
  input  logic [BIT_TOTAL-1:0]  idx,
  input  logic                  avm_waitrequest,
  input  logic                  avm_readdatavalid,
  input  logic [W_BUS-1:0]      avm_readdata,
  output logic [W_ADDR-1:0]     avm_address,
  output logic                  last_issue,
  output logic                  done,
  output logic [SIZE_BLOCK-1:0] block
);
  localparam int BEATS = beats_of(SIZE_BLOCK, W_BUS);
  localparam int CW = $clog2(BEATS + 1);
  logic [CW-1:0] iss_q, iss_d, rcv_q, rcv_d;
  logic [SIZE_BLOCK-1:0] block_q, block_d;
  logic fire, take;
  always_comb begin
    fire = issuing && !avm_waitrequest;
    take = collecting && avm_readdatavalid && (rcv_q < CW'(BEATS));
    last_issue = fire && (iss_q == CW'(BEATS - 1));
    done = take && (rcv_q == CW'(BEATS - 1));
    iss_d = clr ? '0 : iss_q + CW'(fire);
    rcv_d = clr ? '0 : rcv_q + CW'(take);
    block_d = block_q;
    // beat 0 lands in the least-significant slice
    if (take) block_d[rcv_q*W_BUS +: W_BUS] = avm_readdata;
    avm_address = BASE_ADDR + W_ADDR'(idx) * W_ADDR'(bytes_of(SIZE_BLOCK))
                + W_ADDR'(iss_q) * W_ADDR'(bytes_of(W_BUS));
  end
  assign block = block_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      iss_q <= '0;
      rcv_q <= '0;
      block_q <= '0;
    end else begin
      iss_q <= iss_d;
      rcv_q <= rcv_d;
      block_q <= block_d;
    end
endmodule

// File: rtl/cache_rd_ctrl.sv
// cache_rd_ctrl: single-outstanding read cache controller; hits served from the block cache,
// misses refilled from SDRAM in single-word beats
module cache_rd_ctrl
  import cache_pkg::*;
#(
  parameter int SIZE_BLOCK = 32,
  parameter int BIT_TOTAL = 24,
  parameter int W_BUS = 32,
  parameter int W_ADDR = 32,
  parameter logic [W_ADDR-1:0] BASE_ADDR = 32'h0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_avs_read,
  input  logic [BIT_TOTAL-1:0]  i_avs_address,
  output logic                  o_avs_waitrequest,
  output logic [SIZE_BLOCK-1:0] o_avs_readdata,
  output logic                  o_avs_readdatavalid,
  output logic                  o_avm_read,
  output logic [W_ADDR-1:0]     o_avm_address,
  input  logic                  i_avm_waitrequest,
  input  logic [W_BUS-1:0]      i_avm_readdata,
  input  logic                  i_avm_readdatavalid,
  output logic                  o_cache_en,
  output logic                  o_cache_wrt,
  output logic [BIT_TOTAL-1:0]  o_cache_addr,
  output logic [SIZE_BLOCK-1:0] o_cache_data,
  input  logic [SIZE_BLOCK-1:0] i_cache_data,
  input  logic                  i_cache_success,
  output logic [31:0]           o_hit_cnt,
  output logic [31:0]           o_miss_cnt
);
  cache_rd_state_t state_q, state_d;
  logic [BIT_TOTAL-1:0] idx_q, idx_d;
  logic [SIZE_BLOCK-1:0] rdata_q, rdata_d, block;
  logic rvalid_q, rvalid_d, clr, last_issue, done;
  logic [31:0] hit_q, hit_d, miss_q, miss_d;
  logic [W_ADDR-1:0] seq_address;
  cache_fill_seq #(
    .SIZE_BLOCK(SIZE_BLOCK),
    .BIT_TOTAL(BIT_TOTAL),
    .W_BUS(W_BUS),
    .W_ADDR(W_ADDR),
    .BASE_ADDR(BASE_ADDR)
  ) u_seq (
    .clk(i_clk),
    .rst(i_rst),
    .clr(clr),
    .issuing(state_q == MREQ),
    .collecting(state_q == MREQ || state_q == MWAIT),
    .idx(idx_q),
    .avm_waitrequest(i_avm_waitrequest),
    .avm_readdatavalid(i_avm_readdatavalid),
    .avm_readdata(i_avm_readdata),
    .avm_address(seq_address),
    .last_issue(last_issue),
    .done(done),
    .block(block)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    rdata_d = rdata_q;
    rvalid_d = 1'b0;
    hit_d = hit_q;
    miss_d = miss_q;
    clr = 1'b0;
    o_cache_en = 1'b0;
    o_cache_wrt = 1'b0;
    o_cache_addr = '0;
    case (state_q)
      IDLE: if (i_avs_read) begin
        o_cache_en = 1'b1;
        o_cache_addr = i_avs_address;
        idx_d = i_avs_address;
        state_d = PROBE;
      end
      PROBE: if (i_cache_success) begin
        rdata_d = i_cache_data;
        rvalid_d = 1'b1;
        hit_d = sat_inc(hit_q);
        state_d = IDLE;
      end else begin
        miss_d = sat_inc(miss_q);
        clr = 1'b1;
        state_d = MREQ;
      end
      MREQ: state_d = done ? FILL : last_issue ? MWAIT : MREQ;
      MWAIT: state_d = done ? FILL : MWAIT;
      // the write-done flag that follows is deliberately not waited on
      FILL: begin
        o_cache_en = 1'b1;
        o_cache_wrt = 1'b1;
        o_cache_addr = idx_q;
        rdata_d = block;
        rvalid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign o_avs_waitrequest = state_q != IDLE;
  assign o_avm_read = state_q == MREQ;
  assign o_avm_address = o_avm_read ? seq_address : '0;
  assign o_cache_data = (state_q == FILL) ? block : '0;
  assign o_avs_readdata = rdata_q;
  assign o_avs_readdatavalid = rvalid_q;
  assign o_hit_cnt = hit_q;
  assign o_miss_cnt = miss_q;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
      hit_q <= '0;
      miss_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
    end
endmodule
